// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor slice.
package branch_predictor_pkg;

  localparam int unsigned PcWidth  = 32;
  // Instructions are word aligned, so the two low pc bits never index anything.
  localparam int unsigned PcOffset = 2;

  // Weakly not-taken: one below the counter midpoint.
  function automatic int unsigned cnt_reset_val(int unsigned cnt_width);
    return (1 << (cnt_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/ROB-facing bus of the branch predictor: lookup, speculation and commit training.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 6
);
  logic                 rdy;
  logic [PcWidth-1:0]   query_pc;
  logic                 pred_taken;
  logic                 pred_hit;
  logic [PcWidth-1:0]   pred_target;
  logic [IDX_WIDTH-1:0] pred_hist;
  logic                 spec_valid;
  logic                 spec_taken;
  logic                 upd_valid;
  logic                 upd_is_cond;
  logic [PcWidth-1:0]   upd_pc;
  logic                 upd_taken;
  logic [PcWidth-1:0]   upd_target;
  logic [IDX_WIDTH-1:0] upd_hist;
  logic                 rollback;

  modport master (
    output rdy, query_pc, spec_valid, spec_taken, upd_valid, upd_is_cond, upd_pc,
           upd_taken, upd_target, upd_hist, rollback,
    input  pred_taken, pred_hit, pred_target, pred_hist
  );

  modport slave (
    input  rdy, query_pc, spec_valid, spec_taken, upd_valid, upd_is_cond, upd_pc,
           upd_taken, upd_target, upd_hist, rollback,
    output pred_taken, pred_hit, pred_target, pred_hist
  );
endinterface

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped tagged branch target buffer: combinational read, registered write.
module branch_predictor_btb_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_hit,
  output logic [PcWidth-1:0]   rd_target,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [PcWidth-1:0]   wr_target
);
  localparam int unsigned Depth = 1 << IDX_WIDTH;

  logic [Depth-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q    [Depth];
  logic [PcWidth-1:0]   target_q [Depth];

  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_target = rd_hit ? target_q[rd_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Saturating-counter BHT plus tagged BTB; define GSHARE_EN to XOR global history into the index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_WIDTH     = 6,
  parameter int unsigned CNT_WIDTH     = 2,
  parameter int unsigned BTB_IDX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH     = 8
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);
  localparam int unsigned          BhtDepth = 1 << IDX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntReset = CNT_WIDTH'(cnt_reset_val(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] bht_q [BhtDepth];
  logic [CNT_WIDTH-1:0] cnt_old, cnt_new;
  logic [IDX_WIDTH-1:0] lk_hist, tr_hist, lk_idx, tr_idx;
  logic                 bht_we, btb_we;

  assign bht_we = bus.rdy && bus.upd_valid && bus.upd_is_cond;
  assign btb_we = bus.rdy && bus.upd_valid && bus.upd_taken;

`ifdef GSHARE_EN
  logic [IDX_WIDTH-1:0] spec_ghr_q, spec_ghr_d, com_ghr_q, com_ghr_d;

  always_comb begin
    com_ghr_d  = com_ghr_q;
    spec_ghr_d = spec_ghr_q;
    if (bht_we) begin
      com_ghr_d = {com_ghr_q[IDX_WIDTH-2:0], bus.upd_taken};
    end
    // Rollback restores the committed view, including this cycle's commit.
    if (bus.rdy && bus.rollback) begin
      spec_ghr_d = com_ghr_d;
    end else if (bus.rdy && bus.spec_valid) begin
      spec_ghr_d = {spec_ghr_q[IDX_WIDTH-2:0], bus.spec_taken};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_q <= '0;
      com_ghr_q  <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      com_ghr_q  <= com_ghr_d;
    end
  end

  assign lk_hist       = spec_ghr_q;
  assign tr_hist       = bus.upd_hist;
  assign bus.pred_hist = spec_ghr_q;
`else
  logic unused_gshare;
  assign unused_gshare = ^{bus.spec_valid, bus.spec_taken, bus.upd_hist, bus.rollback};
  assign lk_hist       = '0;
  assign tr_hist       = '0;
  assign bus.pred_hist = '0;
`endif

  assign lk_idx         = bus.query_pc[PcOffset +: IDX_WIDTH] ^ lk_hist;
  assign tr_idx         = bus.upd_pc[PcOffset +: IDX_WIDTH] ^ tr_hist;
  assign bus.pred_taken = bht_q[lk_idx][CNT_WIDTH-1];

  always_comb begin
    cnt_old = bht_q[tr_idx];
    cnt_new = cnt_old;
    if (bus.upd_taken) begin
      if (cnt_old != '1) cnt_new = cnt_old + CNT_WIDTH'(1);
    end else if (cnt_old != '0) begin
      cnt_new = cnt_old - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BhtDepth; i++) bht_q[i] <= CntReset;
    end else if (bht_we) begin
      bht_q[tr_idx] <= cnt_new;
    end
  end

  branch_predictor_btb_table #(
    .IDX_WIDTH(BTB_IDX_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.query_pc[PcOffset +: BTB_IDX_WIDTH]),
    .rd_tag   (bus.query_pc[PcOffset + BTB_IDX_WIDTH +: TAG_WIDTH]),
    .rd_hit   (bus.pred_hit),
    .rd_target(bus.pred_target),
    .wr_en    (btb_we),
    .wr_idx   (bus.upd_pc[PcOffset +: BTB_IDX_WIDTH]),
    .wr_tag   (bus.upd_pc[PcOffset + BTB_IDX_WIDTH +: TAG_WIDTH]),
    .wr_target(bus.upd_target)
  );

  // Pc bits outside the index/tag fields carry no prediction information.
  logic unused_pc;
  assign unused_pc = ^{bus.query_pc, bus.upd_pc};

endmodule
